// File: rtl/dav_pkg.sv
// Shared types for the FFT frame sequencer.
// Bin count, magnitude width and sequencer state encoding.
package dav_pkg;

  localparam int N_BINS = 16;
  localparam int MAG_W  = 14;

  typedef logic [MAG_W-1:0] mag_t;

  typedef enum logic [1:0] {
    IDLE,
    RST,
    START,
    LATCH
  } seq_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// 2-flop synchronizer followed by a rising-edge detector.
// Ports: clk, rst (async high), d_in (async level), rise (1-cycle pulse).
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = d_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // Only a 0->1 transition of the synchronized level counts.
  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Runs one FFT per display frame: trigger, reset, start, wait, latch bars.
// Ports: clk_50MHz, rst, vsync, frame_req, fft_done, mag_in[N] ->
//   fft_rst, fft_start, bars[N], bars_valid, busy, overrun_cnt,
//   timeout_flag. Optional macro PEAK_DECAY_EN enables peak-decay bars.
module fft_frame_sequencer
  import dav_pkg::*;
#(
  parameter int N        = dav_pkg::N_BINS,
  parameter int MAG_W    = dav_pkg::MAG_W,
  parameter int RST_HOLD = 250000,
  parameter int TIMEOUT  = 2500000
`ifdef PEAK_DECAY_EN
  ,
  parameter int DECAY_SHIFT = 3
`endif
) (
  input  logic             clk_50MHz,
  input  logic             rst,
  input  logic             vsync,
  input  logic             frame_req,
  input  logic             fft_done,
  input  logic [MAG_W-1:0] mag_in [N],
  output logic             fft_rst,
  output logic             fft_start,
  output logic [MAG_W-1:0] bars [N],
  output logic             bars_valid,
  output logic             busy,
  output logic [7:0]       overrun_cnt,
  output logic             timeout_flag
);

  localparam int MAXC  = (TIMEOUT > RST_HOLD) ? TIMEOUT : RST_HOLD;
  localparam int CNT_W = $clog2(MAXC + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  logic vs_rise;
  logic done_rise;
  logic trig;

  seq_state_t       state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic             fft_rst_q, fft_rst_d;
  logic             fft_start_q, fft_start_d;
  logic             bars_valid_q, bars_valid_d;
  logic             busy_q, busy_d;
  logic [7:0]       ovr_q, ovr_d;
  logic             tmo_q, tmo_d;
  logic [MAG_W-1:0] bars_q [N];
  logic [MAG_W-1:0] bars_d [N];

  sync_edge_det u_vs_sync (
    .clk  (clk_50MHz),
    .rst  (rst),
    .d_in (vsync),
    .rise (vs_rise)
  );

  sync_edge_det u_done_sync (
    .clk  (clk_50MHz),
    .rst  (rst),
    .d_in (fft_done),
    .rise (done_rise)
  );

  // Both sources in one cycle collapse into a single trigger.
  assign trig = vs_rise | frame_req;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    ovr_d        = ovr_q;
    bars_valid_d = 1'b0;
    bars_d       = bars_q;

    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = RST;
          cnt_d   = cnt_t'(RST_HOLD - 1);
        end
      end
      RST: begin
        if (cnt_q == '0) begin
          state_d = START;
          cnt_d   = cnt_t'(TIMEOUT - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      START: begin
        if (done_rise) begin
          state_d = LATCH;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LATCH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (trig && state_q != IDLE && ovr_q != 8'hFF) begin
      ovr_d = ovr_q + 8'd1;
    end

    // Capture on entry to LATCH so bars and bars_valid appear together.
    if (state_q == START && state_d == LATCH) begin
      bars_valid_d = 1'b1;
      for (int i = 0; i < N; i++) begin
`ifdef PEAK_DECAY_EN
        if (mag_in[i] > bars_q[i] - (bars_q[i] >> DECAY_SHIFT)) begin
          bars_d[i] = mag_in[i];
        end else begin
          bars_d[i] = bars_q[i] - (bars_q[i] >> DECAY_SHIFT);
        end
`else
        bars_d[i] = mag_in[i];
`endif
      end
    end

    fft_rst_d   = (state_d == RST);
    fft_start_d = (state_d == START);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fft_rst_q    <= 1'b0;
      fft_start_q  <= 1'b0;
      bars_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      ovr_q        <= 8'd0;
      tmo_q        <= 1'b0;
      for (int i = 0; i < N; i++) begin
        bars_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fft_rst_q    <= fft_rst_d;
      fft_start_q  <= fft_start_d;
      bars_valid_q <= bars_valid_d;
      busy_q       <= busy_d;
      ovr_q        <= ovr_d;
      tmo_q        <= tmo_d;
      bars_q       <= bars_d;
    end
  end

  assign fft_rst      = fft_rst_q;
  assign fft_start    = fft_start_q;
  assign bars         = bars_q;
  assign bars_valid   = bars_valid_q;
  assign busy         = busy_q;
  assign overrun_cnt  = ovr_q;
  assign timeout_flag = tmo_q;

endmodule
